// File: rtl/scr_arb_pkg.sv
// Shared definitions for the screen RAM write arbiter.
//   SCR_ADDR_W / SCR_DATA_W / SCR_DEPTH : default geometry of the screen RAM
//   state_t  : arbiter FSM states (IDLE=0, CLEAR=1)
//   gnt_id_t : writer identifiers; also the bit index into the one-hot grant
package scr_arb_pkg;

  localparam int unsigned SCR_ADDR_W = 13;
  localparam int unsigned SCR_DATA_W = 16;
  localparam int unsigned SCR_DEPTH  = 8192;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : requests, bit 0 = writer A, bit 1 = writer B
//   enable     : grants may be issued this cycle
//   update     : a grant issued this cycle is a real transfer; remember it
//   gnt[1:0]   : one-hot grant (combinational)
// last_grant resets to B so A wins the first contested cycle.
module rr_arb2
  import scr_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       update,
  output logic [1:0] gnt
);

  gnt_id_t last_grant;

  always_comb begin
    gnt = '0;
    if (enable) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == GNT_B) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_B;
    end else if (update && (gnt != 2'b00)) begin
      last_grant <= gnt[1] ? GNT_B : GNT_A;
    end
  end

endmodule

// File: rtl/screen_wr_arbiter.sv
// Owner of the screen2 RAM write port. Two writers (A: life engine,
// B: host loader) share it round-robin; a clear sequencer can fill the
// whole screen with one word. One registered write per cycle, latency 1.
//   pixel_clock, reset_n          : clock, asynchronous active-low reset
//   a_valid/a_addr/a_data/a_ready : writer A handshake (ready combinational)
//   b_valid/b_addr/b_data/b_ready : writer B handshake (ready combinational)
//   clr_start, clr_value          : start full-screen fill with clr_value
//   clr_busy                      : clear sequencer running
//   vblank                        : vertical blanking indicator
//   wren, wraddress, wrdata       : registered screen RAM write port
// Build option: define SCR_VBLANK_GATE_EN to allow writes (arbitrated and
// clear) only while vblank=1; otherwise vblank is ignored.
module screen_wr_arbiter
  import scr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = SCR_ADDR_W,
  parameter int unsigned DATA_W = SCR_DATA_W,
  parameter int unsigned DEPTH  = SCR_DEPTH
)(
  input  logic              pixel_clock,
  input  logic              reset_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  input  logic              vblank,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] wrdata
);

  // Counter is one bit wider than the address so DEPTH = 2**ADDR_W ends
  // on a compare rather than wrapping back to zero.
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W:0]   clr_cnt;
  logic [DATA_W-1:0] clr_val;
  logic              allow;
  logic              arb_en;
  logic [1:0]        gnt;

`ifdef SCR_VBLANK_GATE_EN
  assign allow = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign allow = 1'b1;
`endif

  // A clear request in IDLE takes priority over both writers.
  assign arb_en = (state == ST_IDLE) && !clr_start && allow;

  rr_arb2 u_rr (
    .clk    (pixel_clock),
    .rst_n  (reset_n),
    .req    ({b_valid, a_valid}),
    .enable (arb_en),
    .update (1'b1),
    .gnt    (gnt)
  );

  assign a_ready = gnt[GNT_A];
  assign b_ready = gnt[GNT_B];

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      clr_cnt   <= '0;
      clr_val   <= '0;
      clr_busy  <= 1'b0;
      wren      <= 1'b0;
      wraddress <= '0;
      wrdata    <= '0;
    end else begin
      wren <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state    <= ST_CLEAR;
            clr_busy <= 1'b1;
            clr_val  <= clr_value;
            clr_cnt  <= '0;
          end else if (gnt[GNT_A]) begin
            wren      <= 1'b1;
            wraddress <= a_addr;
            wrdata    <= a_data;
          end else if (gnt[GNT_B]) begin
            wren      <= 1'b1;
            wraddress <= b_addr;
            wrdata    <= b_data;
          end
        end
        ST_CLEAR: begin
          if (allow) begin
            wren      <= 1'b1;
            wraddress <= clr_cnt[ADDR_W-1:0];
            wrdata    <= clr_val;
            clr_cnt   <= clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST) begin
              state    <= ST_IDLE;
              clr_busy <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_wr_arbiter.sv
module tb_screen_wr_arbiter;
  localparam int AW    = 13;
  localparam int DW    = 16;
  localparam int DEPTH = 8192;

  logic          pixel_clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready;
  logic          clr_start = 1'b0;
  logic [DW-1:0] clr_value = '0;
  logic          clr_busy;
  logic          vblank = 1'b0;
  logic          wren;
  logic [AW-1:0] wraddress;
  logic [DW-1:0] wrdata;

  always #5 pixel_clock = ~pixel_clock;

  screen_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .a_valid     (a_valid),
    .a_addr      (a_addr),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .clr_start   (clr_start),
    .clr_value   (clr_value),
    .clr_busy    (clr_busy),
    .vblank      (vblank),
    .wren        (wren),
    .wraddress   (wraddress),
    .wrdata      (wrdata)
  );

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;

  // Reference model: words still to be cleared, next clear address,
  // which writer last moved, and whether each writer has a pending request.
  int            clr_left = 0;
  int            clr_next = 0;
  logic [DW-1:0] clr_word = '0;
  bit            last_was_a = 1'b0;
  bit            a_pend = 1'b0, b_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit allowed();
`ifdef SCR_VBLANK_GATE_EN
    return vblank;
`else
    return 1'b1;
`endif
  endfunction

  task automatic push(input logic [AW-1:0] ad, input logic [DW-1:0] dt);
    wr_t w;
    w.due  = cyc + 1;
    w.addr = ad;
    w.data = dt;
    q.push_back(w);
  endtask

  task automatic step(input bit wa, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit wb, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input bit clr, input logic [DW-1:0] cv);
    bit ea, eb;
    @(posedge pixel_clock);
    #1;
    cyc++;
    if (wa && !a_pend) begin a_pend = 1'b1; a_addr = aa; a_data = ad; end
    if (wb && !b_pend) begin b_pend = 1'b1; b_addr = ba; b_data = bd; end
    a_valid   = a_pend;
    b_valid   = b_pend;
    clr_start = clr;
    clr_value = clr ? cv : DW'($urandom);
`ifdef SCR_VBLANK_GATE_EN
    vblank = ((cyc / 10) % 2) == 0;
`else
    vblank = 1'($urandom_range(0, 1));
`endif
    #1;
    chk("clr_busy", 32'(clr_busy), 32'(clr_left != 0));
    ea = 1'b0;
    eb = 1'b0;
    if (clr_left > 0) begin
      if (allowed()) begin
        push(AW'(clr_next), clr_word);
        clr_next++;
        clr_left--;
      end
    end else if (clr) begin
      clr_left = DEPTH;
      clr_next = 0;
      clr_word = cv;
    end else if (allowed()) begin
      if (a_pend && b_pend) begin
        ea = !last_was_a;
        eb = last_was_a;
      end else begin
        ea = a_pend;
        eb = b_pend;
      end
    end
    chk("a_ready", 32'(a_ready), 32'(ea));
    chk("b_ready", 32'(b_ready), 32'(eb));
    if (ea) begin push(a_addr, a_data); a_pend = 1'b0; last_was_a = 1'b1; end
    if (eb) begin push(b_addr, b_data); b_pend = 1'b0; last_was_a = 1'b0; end
  endtask

  task automatic rstep(input int pa, input int pb, input int pc);
    step($urandom_range(0, 99) < pa, AW'($urandom), DW'($urandom),
         $urandom_range(0, 99) < pb, AW'($urandom), DW'($urandom),
         $urandom_range(0, 999) < pc, DW'($urandom));
  endtask

  task automatic idle_step();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // Asynchronous reset in the middle of a cycle, then model reset.
  task automatic reset_pulse();
    @(posedge pixel_clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    chk("rst_wraddress", 32'(wraddress), 32'd0);
    chk("rst_wrdata", 32'(wrdata), 32'd0);
    q.delete();
    clr_left   = 0;
    clr_next   = 0;
    last_was_a = 1'b0;
    a_pend     = 1'b0;
    b_pend     = 1'b0;
    a_valid    = 1'b0;
    b_valid    = 1'b0;
    clr_start  = 1'b0;
    repeat (2) @(negedge pixel_clock);
    reset_n = 1'b1;
  endtask

  // Monitor: every wren must match the oldest expected write, one cycle
  // after it was accepted; nothing may be written otherwise.
  initial begin
    bit exp_w;
    forever begin
      @(negedge pixel_clock);
      if (reset_n) begin
        if (q.size() > 0 && q[0].due < cyc) begin
          chk("write_latency", 32'(cyc), 32'(q[0].due));
          void'(q.pop_front());
        end
        exp_w = (q.size() > 0) && (q[0].due == cyc);
        chk("wren", 32'(wren), 32'(exp_w));
        if (exp_w) begin
          chk("wraddress", 32'(wraddress), 32'(q[0].addr));
          chk("wrdata", 32'(wrdata), 32'(q[0].data));
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #1;
    chk("init_wren", 32'(wren), 32'd0);
    chk("init_clr_busy", 32'(clr_busy), 32'd0);
    chk("init_wraddress", 32'(wraddress), 32'd0);
    chk("init_a_ready", 32'(a_ready), 32'd0);
    #11;
    reset_n = 1'b1;

    // Single writer A, fixed word.
    step(1'b1, 13'h0005, 16'h1741, 1'b0, '0, '0, 1'b0, '0);
    repeat (3) idle_step();

    // Both writers held after reset: A, B, A, B.
    reset_pulse();
    repeat (4) step(1'b1, AW'($urandom), DW'($urandom), 1'b1, AW'($urandom), DW'($urandom), 1'b0, '0);
    repeat (3) idle_step();

    // Full clear, no competing traffic.
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 16'h0720);
    while (clr_left > 0) idle_step();
    repeat (3) idle_step();

    // Clear started alongside a request; random traffic and ignored
    // clr_start pulses while it runs.
    step(1'b1, AW'($urandom), DW'($urandom), 1'b0, '0, '0, 1'b1, DW'($urandom));
    while (clr_left > 0) rstep(30, 30, 20);
    repeat (4) idle_step();

    // Reset at counter 100 mid-clear, then a fresh clear from address 0.
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, DW'($urandom));
    while (clr_next < 100) rstep(50, 50, 0);
    reset_pulse();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, DW'($urandom));
    while (clr_left > 0) rstep(40, 40, 0);

    // Random contention.
    repeat (1500) rstep(60, 60, 0);
    repeat (4) idle_step();

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
